// File: rtl/scan_priority_encoder_if.sv
// ---------------------------------------------------------------------------
// scan_priority_encoder_if
//
// Purpose: groups the request/handshake/status signals of the sequential
// 16-to-4 scan priority encoder into one bundle.
//
// Signals:
//   load   - capture request vector (requester -> encoder)
//   w      - N-bit multi-hot request vector (requester -> encoder)
//   ready  - consumer accepts y this cycle (consumer -> encoder)
//   y      - W-bit encoded index of current pending bit (encoder -> consumer)
//   valid  - y holds a pending index (encoder -> consumer)
//   busy   - batch in progress (encoder -> consumer)
//   done   - one-cycle pulse, last index of batch accepted
//   none   - one-cycle pulse, load captured an all-zero vector
//   count  - W+1-bit number of indices accepted in current/last batch
//
// Modports:
//   master - requester/consumer side (drives load, w, ready)
//   slave  - encoder side (drives y, valid, busy, done, none, count)
// ---------------------------------------------------------------------------
interface scan_priority_encoder_if #(
    parameter int N = 16,
    parameter int W = 4
);
    logic         load;
    logic [N-1:0] w;
    logic         ready;
    logic [W-1:0] y;
    logic         valid;
    logic         busy;
    logic         done;
    logic         none;
    logic [W:0]   count;

    modport master (
        output load, w, ready,
        input  y, valid, busy, done, none, count
    );

    modport slave (
        input  load, w, ready,
        output y, valid, busy, done, none, count
    );
endinterface

// File: rtl/scan_priority_encoder.sv
// ---------------------------------------------------------------------------
// scan_priority_encoder
//
// Purpose: sequential 16-to-4 encoder, the inverse of the 4-to-16 decoder.
// A multi-hot request vector is captured on load; the binary index of every
// set bit is then emitted one per valid/ready handshake, lowest index first,
// so a decoder-driven select bank can regenerate the one-hot selects in order.
//
// Ports:
//   clk    - rising-edge clock
//   resetn - asynchronous active-low reset
//   En     - global enable; 0 freezes all state and masks valid/done/none
//   bus    - scan_priority_encoder_if.slave (load, w, ready, y, valid, busy,
//            done, none, count)
// ---------------------------------------------------------------------------
module scan_priority_encoder #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic                            En,
    scan_priority_encoder_if.slave          bus
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t       r_state;
    logic [N-1:0] r_pending;
    logic [W-1:0] r_y;
    logic         r_valid;
    logic         r_done;
    logic         r_none;
    logic [W:0]   r_count;

    state_t       w_nextState;
    logic [N-1:0] w_nextPending;
    logic [W-1:0] w_nextY;
    logic         w_nextValid;
    logic         w_nextDone;
    logic         w_nextNone;
    logic [W:0]   w_nextCount;

    logic         w_validOut;
    logic         w_xfer;
    logic [N-1:0] w_clrMask;
    logic [N-1:0] w_remaining;

    // Lowest set index wins; scanning downward lets the last hit be the
    // lowest one. An all-zero vector yields 0, but callers only use the
    // result when at least one bit is set.
    function automatic logic [W-1:0] lowestIndex(input logic [N-1:0] vec);
        logic [W-1:0] idx;
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (vec[k]) begin
                idx = k[W-1:0];
            end
        end
        return idx;
    endfunction

    // Enable masks the handshake and the pulses combinationally so that a
    // frozen block can neither complete a transfer nor report an event.
    assign w_validOut = r_valid & En;
    assign w_xfer     = w_validOut & bus.ready;

    assign bus.y     = r_y;
    assign bus.valid = w_validOut;
    assign bus.busy  = (r_state == EMIT);
    assign bus.done  = r_done & En;
    assign bus.none  = r_none & En;
    assign bus.count = r_count;

    // State register: everything advances only when En is high; reset
    // discards any batch in flight immediately.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= IDLE;
            r_pending <= '0;
            r_y       <= '0;
            r_valid   <= 1'b0;
            r_done    <= 1'b0;
            r_none    <= 1'b0;
            r_count   <= '0;
        end else if (En) begin
            r_state   <= w_nextState;
            r_pending <= w_nextPending;
            r_y       <= w_nextY;
            r_valid   <= w_nextValid;
            r_done    <= w_nextDone;
            r_none    <= w_nextNone;
            r_count   <= w_nextCount;
        end
    end

    // Next-state logic. A load is refused while the done pulse is still
    // showing, so a load held across the end of a batch cannot restart it
    // until the cycle after the return to IDLE.
    always_comb begin
        w_nextState   = r_state;
        w_nextPending = r_pending;
        w_nextY       = r_y;
        w_nextValid   = r_valid;
        w_nextDone    = 1'b0;
        w_nextNone    = 1'b0;
        w_nextCount   = r_count;
        w_clrMask     = '0;
        w_clrMask[r_y] = 1'b1;
        w_remaining   = r_pending & ~w_clrMask;

        case (r_state)
            IDLE: begin
                if (bus.load && !r_done) begin
                    w_nextCount = '0;
                    if (|bus.w) begin
                        w_nextPending = bus.w;
                        w_nextY       = lowestIndex(bus.w);
                        w_nextValid   = 1'b1;
                        w_nextState   = EMIT;
                    end else begin
                        w_nextNone    = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (w_xfer) begin
                    w_nextPending = w_remaining;
                    w_nextCount   = r_count + (W+1)'(1);
                    if (|w_remaining) begin
                        w_nextY     = lowestIndex(w_remaining);
                    end else begin
                        w_nextValid = 1'b0;
                        w_nextDone  = 1'b1;
                        w_nextState = IDLE;
                    end
                end
            end
            default: begin
                w_nextState = IDLE;
                w_nextValid = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_scan_priority_encoder.sv
// ---------------------------------------------------------------------------
// tb_scan_priority_encoder
//
// Purpose: directed self-checking bench for scan_priority_encoder. Inputs are
// driven 1 time unit after each rising edge and outputs are sampled at that
// same point, so every observation reflects the state after the last edge.
// ---------------------------------------------------------------------------
module tb_scan_priority_encoder;

    localparam int N = 16;
    localparam int W = 4;

    logic clk;
    logic resetn;
    logic En;

    int checkCount;
    int passCount;

    scan_priority_encoder_if #(.N(N), .W(W)) bus ();

    scan_priority_encoder #(.N(N), .W(W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .En     (En),
        .bus    (bus.slave)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just past it.
    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic loadV, input logic [N-1:0] wV,
                                 input logic readyV);
        bus.load  = loadV;
        bus.w     = wV;
        bus.ready = readyV;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    endtask

    task automatic checkState(input string tag, input logic [W-1:0] expY,
                              input logic expValid, input logic expBusy,
                              input logic expDone, input logic expNone,
                              input logic [W:0] expCount);
        checkOutput({tag, ".y"},     32'(bus.y),     32'(expY));
        checkOutput({tag, ".valid"}, 32'(bus.valid), 32'(expValid));
        checkOutput({tag, ".busy"},  32'(bus.busy),  32'(expBusy));
        checkOutput({tag, ".done"},  32'(bus.done),  32'(expDone));
        checkOutput({tag, ".none"},  32'(bus.none),  32'(expNone));
        checkOutput({tag, ".count"}, 32'(bus.count), 32'(expCount));
    endtask

    initial begin
        logic [W-1:0] sparseSeq [4];
        sparseSeq[0] = 4'd0;
        sparseSeq[1] = 4'd5;
        sparseSeq[2] = 4'd10;
        sparseSeq[3] = 4'd15;

        checkCount = 0;
        passCount  = 0;
        resetn     = 1'b0;
        En         = 1'b1;
        applyStimulus(1'b0, 16'h0000, 1'b0);

        // Power-on reset values.
        #3;
        checkState("reset", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        waitCycle();
        waitCycle();
        resetn = 1'b1;
        waitCycle();
        checkState("idle", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);

        // Sparse vector 0x8421 with ready held high: 0,5,10,15 back to back.
        $display("[TB] sparse vector 8421");
        applyStimulus(1'b1, 16'h8421, 1'b1);
        waitCycle();
        applyStimulus(1'b0, 16'h0000, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checkState($sformatf("sparse%0d", i), sparseSeq[i], 1'b1, 1'b1,
                       1'b0, 1'b0, 5'(i));
            waitCycle();
        end
        checkState("sparseDone", 4'd15, 1'b0, 1'b0, 1'b1, 1'b0, 5'd4);
        waitCycle();
        checkState("sparseAfter", 4'd15, 1'b0, 1'b0, 1'b0, 1'b0, 5'd4);

        // Backpressure on 0x0006: y=1 held for three stalled cycles.
        $display("[TB] backpressure 0006");
        applyStimulus(1'b1, 16'h0006, 1'b0);
        waitCycle();
        applyStimulus(1'b0, 16'h0000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checkState($sformatf("stall%0d", i), 4'd1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
            waitCycle();
        end
        checkState("stall3", 4'd1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        waitCycle();
        checkState("bpSecond", 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 5'd1);
        waitCycle();
        checkState("bpDone", 4'd2, 1'b0, 1'b0, 1'b1, 1'b0, 5'd2);
        waitCycle();

        // All-ones vector: 0..15 over 16 cycles, count reaches 16.
        $display("[TB] all ones FFFF");
        applyStimulus(1'b1, 16'hFFFF, 1'b1);
        waitCycle();
        applyStimulus(1'b0, 16'h0000, 1'b1);
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("ones%0d.y", i), 32'(bus.y), i);
            checkOutput($sformatf("ones%0d.count", i), 32'(bus.count), i);
            checkOutput($sformatf("ones%0d.done", i), 32'(bus.done), 0);
            waitCycle();
        end
        checkState("onesDone", 4'd15, 1'b0, 1'b0, 1'b1, 1'b0, 5'b10000);
        waitCycle();
        checkState("onesAfter", 4'd15, 1'b0, 1'b0, 1'b0, 1'b0, 5'b10000);

        // Zero vector: none pulses once, no batch starts.
        $display("[TB] zero vector");
        applyStimulus(1'b1, 16'h0000, 1'b1);
        waitCycle();
        applyStimulus(1'b0, 16'h0000, 1'b1);
        checkState("zeroNone", 4'd15, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
        waitCycle();
        checkState("zeroAfter", 4'd15, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);

        // Enable freeze during a 0x0300 batch.
        $display("[TB] enable freeze 0300");
        applyStimulus(1'b1, 16'h0300, 1'b1);
        waitCycle();
        applyStimulus(1'b0, 16'h0000, 1'b1);
        En = 1'b0;
        #1;
        checkState("freezeStart", 4'd8, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
        for (int i = 0; i < 4; i++) begin
            waitCycle();
            checkState($sformatf("freeze%0d", i), 4'd8, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
        end
        En = 1'b1;
        #1;
        checkState("thaw", 4'd8, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
        waitCycle();
        checkState("thawSecond", 4'd9, 1'b1, 1'b1, 1'b0, 1'b0, 5'd1);
        waitCycle();
        checkState("thawDone", 4'd9, 1'b0, 1'b0, 1'b1, 1'b0, 5'd2);
        waitCycle();

        // Loads while busy and on the done cycle are ignored.
        $display("[TB] load ignored while busy");
        applyStimulus(1'b1, 16'h0003, 1'b0);
        waitCycle();
        checkState("busyFirst", 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
        applyStimulus(1'b1, 16'hFFFF, 1'b1);
        waitCycle();
        checkState("busySecond", 4'd1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd1);
        waitCycle();
        checkState("busyDone", 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd2);
        waitCycle();
        checkState("doneCycleLoad", 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2);
        applyStimulus(1'b0, 16'h0000, 1'b0);
        waitCycle();

        // Asynchronous reset in the middle of a 0x00F0 batch.
        $display("[TB] reset mid-batch 00F0");
        applyStimulus(1'b1, 16'h00F0, 1'b1);
        waitCycle();
        applyStimulus(1'b0, 16'h0000, 1'b1);
        checkState("rstFirst", 4'd4, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
        waitCycle();
        checkState("rstSecond", 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 5'd1);
        applyStimulus(1'b0, 16'h0000, 1'b0);
        #2;
        resetn = 1'b0;
        #1;
        checkState("rstAsync", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        #2;
        resetn = 1'b1;
        applyStimulus(1'b0, 16'h0000, 1'b1);
        waitCycle();
        checkState("rstIdle", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/scan_priority_encoder.md
Name: scan_priority_encoder

Overview:
- Sequential 16-to-4 encoder; the inverse of the team's 4-to-16 decoder.
- Captures a multi-hot 16-bit request vector on `load`.
- Emits the binary index of every set bit, one per handshake, lowest index first.
- Sits in front of a decoder-driven select bank so a batch of one-hot selects can be regenerated in order.

Parameters:
N, 16, request vector width (number of decoder outputs)
W, 4, index width; must equal log2(N)

Ports:
clk  input  1  rising-edge clock
resetn  input  1  asynchronous active-low reset
En  input  1  global enable; 0 freezes all state
load  input  1  capture request vector (honoured only in IDLE with En=1)
w  input  N  request vector; bit k set = index k pending
ready  input  1  consumer accepts y this cycle
y  output  W  encoded index of current pending bit (registered)
valid  output  1  y holds a pending index (registered)
busy  output  1  batch in progress (state != IDLE)
done  output  1  one-cycle pulse: last index of batch accepted
none  output  1  one-cycle pulse: load captured an all-zero vector
count  output  W+1  indices accepted in current/last batch (0..N)

Behaviour:
- Reset (resetn=0, async, any state): state=IDLE, pending=0, y=0, valid=0, done=0, none=0, count=0. Takes effect immediately, including mid-batch; the batch is discarded.
- All registers update on the rising edge of clk only when En=1. With En=0 everything holds, except:
  - valid is forced 0 combinationally, so no transfer can occur;
  - done and none are forced 0.
- Internal pending register: N bits.
- Priority: lowest set index wins (bit 0 highest priority), matching decoder output y[0] for input 0.
- IDLE:
  - busy=0, valid=0.
  - On load=1, w≠0: pending<=w, y<=index of lowest set bit of w, valid<=1, count<=0, state<=EMIT. Latency is 1 cycle: first index is valid the cycle after load.
  - On load=1, w=0: none<=1 for one cycle, count<=0, stay in IDLE.
- EMIT:
  - busy=1, valid=1.
  - y is stable while ready=0; w and load are ignored.
  - On valid && ready (a transfer):
    - clear pending[y];
    - count<=count+1;
    - if pending bits remain: y<=lowest remaining index, valid stays 1 (back-to-back, one index per cycle at full throughput);
    - if none remain: valid<=0, done<=1 for one cycle, state<=IDLE.
- A load asserted on the same cycle done is produced is ignored. The next load is accepted from the cycle after the return to IDLE.
- count holds its final value in IDLE until the next accepted load.
- Width: count is W+1 bits so a full-vector batch reads N (16) without wrap.
- The index is computed by a loop or case over pending. No latches: every output of the combinational block is defaulted each evaluation.

Test Plan:
- Reset mid-batch: load w=16'h00F0, accept one index, then pulse resetn=0 asynchronously between clock edges -> immediately valid=0, busy=0, y=0, count=0; after release, state is IDLE.
- Sparse vector with ready held 1: load w=16'h8421 -> valid from next cycle, y sequence 0,5,10,15 on consecutive cycles; done pulses with the y=15 transfer cycle+1; count=4.
- Backpressure: load w=16'h0006, ready=0 for 3 cycles -> y=1 stable with valid=1; ready=1 -> y=2 next cycle; then done, count=2.
- All-ones and zero vectors: load 16'hFFFF with ready=1 -> y=0..15 over 16 cycles, count=16 (5'b10000), done once. Load 16'h0000 -> none pulses 1 cycle, busy stays 0, valid stays 0.
- Enable freeze: during a w=16'h0300 batch drop En for 4 cycles with ready=1 -> valid=0, no index lost; raise En -> resumes at y=8 then y=9.
- Load ignored when busy: assert load with w=16'hFFFF during an EMIT of w=16'h0003 -> only indices 0,1 are emitted; a load on the done cycle is also ignored.
